// File: rtl/ev20_defs_pkg.sv
// EV-20 microinstruction definitions shared by the instruction path.
// Field bit positions, the default word width and the clear-carry void word.
package ev20_defs;

   localparam int unsigned INS_W_DEF = 14;

   // Microinstruction field bit positions (LSB of each field)
   localparam int unsigned BIT_ALU_OP    = 0;
   localparam int unsigned BIT_SRC_SEL   = 4;
   localparam int unsigned BIT_DST_SEL   = 6;
   localparam int unsigned BIT_CLR_CARRY = 9;
   localparam int unsigned BIT_SEQ_CTL   = 10;

   localparam logic [INS_W_DEF-1:0] CLEAR_CARRY = INS_W_DEF'(1) << BIT_CLR_CARRY;

   typedef enum logic [1:0] {
      IR_HOLD,
      IR_LOAD,
      IR_BUBBLE
   } ir_src_e;

endpackage

// File: rtl/ins_fifo.sv
// Generic synchronous FIFO with clear; full/empty are derived from the count,
// pointers wrap naturally at DEPTH (power of two).
module ins_fifo #(
   parameter int unsigned WIDTH = 14,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full & ~clear;
   assign pop_ok  = pop & ~empty & ~clear;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: slots are only read after being written.
   always_ff @(posedge clk) begin
      if (push_ok && !reset) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/ins_prefetch_register.sv
// EV-20 instruction register fed by a prefetch FIFO; bubbles and flushes load
// the void word, and is_void overrides the output combinationally.
module ins_prefetch_register
   import ev20_defs::*;
#(
   parameter int unsigned          INS_W    = INS_W_DEF,
   parameter int unsigned          DEPTH    = 4,
   parameter logic [INS_W-1:0]     VOID_INS = INS_W'(CLEAR_CARRY)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [INS_W-1:0]             in_ins,
   output logic                         in_ready,
   input  logic                         advance,
   input  logic                         flush,
   input  logic                         is_void,
   output logic [INS_W-1:0]             out_ins,
   output logic                         out_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   logic [INS_W-1:0] ir_q, ir_d;
   logic             valid_q, valid_d;
   logic [INS_W-1:0] head;
   logic             q_full, q_empty;
   logic             push, pop;
   ir_src_e          ir_src;

   // in_ready depends only on registered count, never on advance.
   assign in_ready = ~q_full;
   assign push     = in_valid & in_ready & ~flush;
   assign pop      = advance & ~q_empty & ~flush;

   ins_fifo #(
      .WIDTH (INS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .wdata (in_ins),
      .rdata (head),
      .count (count),
      .full  (q_full),
      .empty (q_empty)
   );

   always_comb begin
      ir_src = IR_HOLD;
      if (flush)        ir_src = IR_BUBBLE;
      else if (advance) ir_src = q_empty ? IR_BUBBLE : IR_LOAD;

      ir_d    = ir_q;
      valid_d = valid_q;
      case (ir_src)
         IR_LOAD: begin
            ir_d    = head;
            valid_d = 1'b1;
         end
         IR_BUBBLE: begin
            ir_d    = VOID_INS;
            valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         valid_q <= valid_d;
      end
   end

   assign out_ins   = is_void ? VOID_INS : ir_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_ins_prefetch_register.sv
// Self-checking bench for ins_prefetch_register: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_ins_prefetch_register;

   localparam int unsigned INS_W = 14;
   localparam int unsigned DEPTH = 4;
   localparam logic [INS_W-1:0] VOID = 14'h0200;

   logic             clk = 1'b0;
   logic             reset, in_valid, advance, flush, is_void;
   logic [INS_W-1:0] in_ins;
   logic             in_ready, out_valid;
   logic [INS_W-1:0] out_ins;
   logic [2:0]       count;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Reference model state
   logic [INS_W-1:0] mq[$];
   logic [INS_W-1:0] m_ir;
   logic             m_vld;

   ins_prefetch_register #(
      .INS_W    (INS_W),
      .DEPTH    (DEPTH),
      .VOID_INS (VOID)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ins    (in_ins),
      .in_ready  (in_ready),
      .advance   (advance),
      .flush     (flush),
      .is_void   (is_void),
      .out_ins   (out_ins),
      .out_valid (out_valid),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Apply the architectural rules to the current inputs, then advance one edge.
   task automatic tick();
      bit ready;
      if (reset) begin
         mq.delete();
         m_ir  = '0;
         m_vld = 1'b0;
      end else if (flush) begin
         mq.delete();
         m_ir  = VOID;
         m_vld = 1'b0;
      end else begin
         ready = (mq.size() < DEPTH);
         if (advance) begin
            if (mq.size() > 0) begin
               m_ir  = mq.pop_front();
               m_vld = 1'b1;
            end else begin
               m_ir  = VOID;
               m_vld = 1'b0;
            end
         end
         if (in_valid && ready) mq.push_back(in_ins);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; advance = 0; flush = 0; is_void = 0; in_ins = '0;
   endtask

   task automatic test_reset();
      reset = 1; idle_inputs();
      tick(); tick();
      reset = 0;
      tick();
      vectors++;
      if (out_ins !== 14'h0000) begin miscompares++; $display("FAIL reset_out_ins got %h want 0000", out_ins); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++;
      if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_push_advance();
      in_valid = 1; in_ins = 14'h1234; tick();
      in_ins = 14'h0ABC; tick();
      in_valid = 0;
      vectors++;
      if (count !== 3'd2) begin miscompares++; $display("FAIL pa_count2 got %0d want 2", count); end
      advance = 1; tick();
      vectors++;
      if (out_ins !== 14'h1234 || out_valid !== 1'b1 || count !== 3'd1) begin
         miscompares++; $display("FAIL pa_first got %h/%b/%0d want 1234/1/1", out_ins, out_valid, count);
      end
      tick();
      advance = 0;
      vectors++;
      if (out_ins !== 14'h0ABC || out_valid !== 1'b1 || count !== 3'd0) begin
         miscompares++; $display("FAIL pa_second got %h/%b/%0d want 0abc/1/0", out_ins, out_valid, count);
      end
   endtask

   task automatic test_full();
      logic [INS_W-1:0] words [5];
      for (int i = 0; i < 5; i++) words[i] = INS_W'($urandom);
      in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         in_ins = words[i];
         tick();
         if (i == 3) begin
            vectors++;
            if (count !== 3'd4 || in_ready !== 1'b0) begin
               miscompares++; $display("FAIL full_at4 got count=%0d ready=%b want 4/0", count, in_ready);
            end
         end
      end
      in_valid = 0;
      vectors++;
      if (count !== 3'd4) begin miscompares++; $display("FAIL full_5th_rejected got count=%0d want 4", count); end
      advance = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (out_ins !== words[i] || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL full_order[%0d] got %h/%b want %h/1", i, out_ins, out_valid, words[i]);
         end
      end
      tick();
      advance = 0;
      vectors++;
      if (out_ins !== VOID || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL full_5th_absent got %h/%b want 0200/0", out_ins, out_valid);
      end
   endtask

   task automatic test_empty_bubble();
      advance = 1; tick(); advance = 0;
      vectors++;
      if (out_ins !== VOID || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL bubble got %h/%b want 0200/0", out_ins, out_valid);
      end
      // Push while advancing on empty: still a bubble, word is queued.
      in_valid = 1; in_ins = 14'h0011; advance = 1; tick();
      in_valid = 0;
      vectors++;
      if (out_ins !== VOID || out_valid !== 1'b0 || count !== 3'd1) begin
         miscompares++; $display("FAIL no_bypass got %h/%b/%0d want 0200/0/1", out_ins, out_valid, count);
      end
      tick(); advance = 0;
      vectors++;
      if (out_ins !== 14'h0011 || out_valid !== 1'b1) begin
         miscompares++; $display("FAIL after_bubble got %h/%b want 0011/1", out_ins, out_valid);
      end
   endtask

   task automatic test_flush();
      in_valid = 1;
      for (int i = 0; i < 3; i++) begin in_ins = INS_W'(14'h0100 + i); tick(); end
      in_ins = 14'h3FFF; advance = 1; flush = 1; tick();
      idle_inputs();
      vectors++;
      if (count !== 3'd0 || out_ins !== VOID || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL flush got %0d/%h/%b want 0/0200/0", count, out_ins, out_valid);
      end
      advance = 1; tick(); advance = 0;
      vectors++;
      if (out_ins !== VOID || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL flush_dropped got %h/%b want 0200/0", out_ins, out_valid);
      end
   endtask

   task automatic test_is_void();
      in_valid = 1; in_ins = 14'h1FFF; tick();
      in_ins = 14'h0222; advance = 1; tick();
      in_valid = 0; advance = 0;
      is_void = 1; #1;
      vectors++;
      if (out_ins !== VOID || out_valid !== 1'b1 || count !== 3'd1) begin
         miscompares++; $display("FAIL is_void_on got %h/%b/%0d want 0200/1/1", out_ins, out_valid, count);
      end
      is_void = 0; #1;
      vectors++;
      if (out_ins !== 14'h1FFF || out_valid !== 1'b1 || count !== 3'd1) begin
         miscompares++; $display("FAIL is_void_off got %h/%b/%0d want 1fff/1/1", out_ins, out_valid, count);
      end
   endtask

   task automatic test_random();
      logic [INS_W-1:0] exp_out;
      for (int n = 0; n < 600; n++) begin
         reset    = ($urandom_range(0, 99) == 0);
         flush    = ($urandom_range(0, 29) == 0);
         in_valid = ($urandom_range(0, 99) < 60);
         advance  = ($urandom_range(0, 99) < 45);
         in_ins   = INS_W'($urandom);
         is_void  = 0;
         tick();
         is_void  = ($urandom_range(0, 9) == 0);
         #1;
         exp_out = is_void ? VOID : m_ir;
         vectors++;
         if (out_ins !== exp_out) begin
            miscompares++; $display("FAIL rnd_out_ins[%0d] got %h want %h", n, out_ins, exp_out);
         end
         vectors++;
         if (out_valid !== m_vld) begin
            miscompares++; $display("FAIL rnd_out_valid[%0d] got %b want %b", n, out_valid, m_vld);
         end
         vectors++;
         if (count !== 3'(mq.size())) begin
            miscompares++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, count, mq.size());
         end
         vectors++;
         if (in_ready !== (mq.size() < DEPTH)) begin
            miscompares++; $display("FAIL rnd_in_ready[%0d] got %b want %b", n, in_ready, mq.size() < DEPTH);
         end
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      m_ir = '0; m_vld = 0;
      test_reset();
      test_push_advance();
      test_full();
      test_empty_bubble();
      test_flush();
      test_is_void();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
